// File: rtl/audio_pkg.sv
// Constants shared by the audio output path: default sample width, mid-scale
// code and the dither LFSR seed/taps.
package audio_pkg;

   localparam int          DEFAULT_SAMPLE_W = 8;
   localparam int          MIDSCALE         = 2 ** (DEFAULT_SAMPLE_W - 1);
   localparam logic [15:0] LFSR_SEED        = 16'hACE1;
   // Taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS        = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] state);
      return {state[14:0], ^(state & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with occupancy-derived full/empty and a
// combinational head read so a pop can be consumed on the same edge.
module sample_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      level_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level_reg == (AW+1)'(DEPTH));
   assign empty   = (level_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr_reg];
   assign level   = level_reg;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/pdm_sample_modulator.sv
// PCM-to-PDM output stage: FIFO-buffered samples released every OSR clocks
// into a first-order error-feedback modulator. Optional dither: PDM_DITHER_EN.
module pdm_sample_modulator
   import audio_pkg::*;
#(
   parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
   parameter int OSR        = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ena,
   input  logic                        s_valid,
   input  logic [SAMPLE_W-1:0]         s_data,
   output logic                        s_ready,
   output logic                        pdm_out,
   output logic                        underrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int                CNT_W     = $clog2(OSR);
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(OSR - 1);

   logic [CNT_W-1:0]    tick_cnt_reg;
   logic [SAMPLE_W-1:0] cur_sample_reg;
   logic [SAMPLE_W-1:0] acc_reg;
   logic                pdm_reg;
   logic [SAMPLE_W-1:0] fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                tick;
   logic                pop;
   logic                dither;
   logic [SAMPLE_W:0]   acc_next;

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (s_valid && s_ready),
      .wr_data (s_data),
      .pop     (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign s_ready  = !fifo_full;
   assign tick     = ena && (tick_cnt_reg == TICK_LAST);
   assign pop      = tick && !fifo_empty;
   assign underrun = tick && fifo_empty;
   assign pdm_out  = pdm_reg;

`ifdef PDM_DITHER_EN
   logic [15:0] lfsr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr_reg <= LFSR_SEED;
      else if (ena)
         lfsr_reg <= lfsr_step(lfsr_reg);
   end

   assign dither = lfsr_reg[0];
`else
   assign dither = 1'b0;
`endif

   // The carry out of acc + sample is the PDM bit; the low bits are the error
   assign acc_next = {1'b0, acc_reg} + {1'b0, cur_sample_reg} + (SAMPLE_W+1)'(dither);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_reg   <= '0;
         cur_sample_reg <= '0;
         acc_reg        <= '0;
         pdm_reg        <= 1'b0;
      end else if (ena) begin
         tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
         if (pop)
            cur_sample_reg <= fifo_head;
         acc_reg <= acc_next[SAMPLE_W-1:0];
         pdm_reg <= acc_next[SAMPLE_W];
      end else begin
         pdm_reg <= 1'b0;
      end
   end

endmodule
